// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse position tracker:
// packet/receiver state encodings, byte0 field positions and frame length.
package mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        UPDATE
    } pkt_state_t;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_t;

    localparam int B0_LEFT  = 0;
    localparam int B0_RIGHT = 1;
    localparam int B0_SYNC  = 3;
    localparam int B0_XSIGN = 4;
    localparam int B0_YSIGN = 5;
    localparam int B0_XOVF  = 6;
    localparam int B0_YOVF  = 7;

    localparam int FRAME_LEN = 11;

    // Data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host bit receiver: synchronizes the bus, samples on ps2_clk
// falling edges, checks start/parity/stop and drops stalled partial frames.
module ps2_rx
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_prev;
    logic          fall;
    logic          bit_in;

    rx_state_t     state, state_nxt;
    logic [3:0]    bit_cnt;
    logic [9:0]    frame;
    logic [TW-1:0] idle_cnt;
    logic          last_bit;
    logic          timeout;
    logic          frame_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= '0;
            dat_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall     = clk_prev & ~clk_sync[1];
    assign bit_in   = dat_sync[1];
    assign last_bit = (state == RX_SHIFT) && fall && (bit_cnt == 4'(FRAME_LEN - 1));
    assign timeout  = (state == RX_SHIFT) && !fall && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    // frame[0] is the start bit, frame[8:1] data, frame[9] parity; bit_in is the stop bit.
    assign frame_ok = ~frame[0] & bit_in & odd_parity_ok(frame[9:1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (fall) state_nxt = RX_SHIFT;
            RX_SHIFT: if (last_bit || timeout) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == RX_IDLE) begin
                idle_cnt <= '0;
                bit_cnt  <= fall ? 4'd1 : 4'd0;
            end else if (fall) begin
                idle_cnt <= '0;
                if (last_bit) begin
                    bit_cnt    <= '0;
                    byte_valid <= frame_ok;
                    frame_err  <= ~frame_ok;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (timeout) begin
                bit_cnt   <= '0;
                idle_cnt  <= '0;
                frame_err <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end

    // Frame bits are pure data; they are only consumed once a full frame has arrived.
    always_ff @(posedge clk) begin
        if (fall && !last_bit) frame[bit_cnt] <= bit_in;
        if (last_bit)          rx_byte        <= frame[8:1];
    end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Assembles 3-byte PS/2 mouse packets into a clamped cursor position and
// button state, pulsing evt for one cycle whenever a packet is applied.
module mouse_pos_tracker
    import mouse_pkg::*;
#(
    parameter int X_MAX          = 1023,
    parameter int Y_MAX          = 767,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        left,
    output logic        right,
    output logic        evt
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    pkt_state_t state, state_nxt;

    logic       btn_l, btn_r, x_sign, y_sign, x_ovf, y_ovf;
    logic [7:0] bx, by;

    logic signed [13:0] dx, dy, x_sum, y_sum;

    function automatic logic [11:0] clamp(input logic signed [13:0] v, input int hi);
        if (v < 14'sd0)     return 12'd0;
        if (int'(v) > hi)   return 12'(hi);
        return v[11:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_B0;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_B0: if (byte_valid && rx_byte[B0_SYNC]) state_nxt = WAIT_B1;
            WAIT_B1: if (byte_valid) state_nxt = WAIT_B2;
            WAIT_B2: if (byte_valid) state_nxt = UPDATE;
            UPDATE:  state_nxt = WAIT_B0;
            default: state_nxt = WAIT_B0;
        endcase
        if (frame_err) state_nxt = WAIT_B0;
    end

    // Stage 0: capture packet fields as bytes arrive.
    always_ff @(posedge clk) begin
        if (byte_valid) begin
            case (state)
                WAIT_B0: begin
                    btn_l  <= rx_byte[B0_LEFT];
                    btn_r  <= rx_byte[B0_RIGHT];
                    x_sign <= rx_byte[B0_XSIGN];
                    y_sign <= rx_byte[B0_YSIGN];
                    x_ovf  <= rx_byte[B0_XOVF];
                    y_ovf  <= rx_byte[B0_YOVF];
                end
                WAIT_B1: bx <= rx_byte;
                WAIT_B2: by <= rx_byte;
                default: ;
            endcase
        end
    end

    // 14-bit signed sums cannot wrap: |delta| <= 256 and positions stay below 4096.
    assign dx    = x_ovf ? 14'sd0 : $signed({{6{x_sign}}, bx});
    assign dy    = y_ovf ? 14'sd0 : $signed({{6{y_sign}}, by});
    assign x_sum = $signed({2'b00, xpos}) + dx;
    assign y_sum = $signed({2'b00, ypos}) - dy;

    // Stage 1: apply the packet to the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xpos  <= '0;
            ypos  <= '0;
            left  <= 1'b0;
            right <= 1'b0;
            evt   <= 1'b0;
        end else begin
            evt <= 1'b0;
            if (state == UPDATE) begin
                xpos  <= clamp(x_sum, X_MAX);
                ypos  <= clamp(y_sum, Y_MAX);
                left  <= btn_l;
                right <= btn_r;
                evt   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Scoreboard bench: a packet-level model predicts each cursor update, a
// monitor pops predictions on every evt pulse and checks outputs hold between.
module tb_mouse_pos_tracker;

    localparam int X_MAX = 1023;
    localparam int Y_MAX = 767;
    localparam int TMO   = 400;
    localparam int HALF  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic [11:0] xpos, ypos;
    logic        left, right, evt;

    always #5 clk = ~clk;

    mouse_pos_tracker #(
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .xpos    (xpos),
        .ypos    (ypos),
        .left    (left),
        .right   (right),
        .evt     (evt)
    );

    typedef struct {
        int x;
        int y;
        bit l;
        bit r;
    } exp_t;

    exp_t exp_q[$];
    int   pend[$];
    int   mx, my;
    bit   ml, mr;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Packet-level reference: bad frames drop the partial packet, header bytes
    // without bit3 are skipped, three good bytes produce one update.
    task automatic model_frame(input int b, input bit bad);
        logic [7:0] h;
        int dx, dy;
        if (bad) begin
            pend.delete();
            return;
        end
        h = 8'(b);
        if (pend.size() == 0 && !h[3]) return;
        pend.push_back(b);
        if (pend.size() == 3) begin
            h  = 8'(pend[0]);
            dx = h[6] ? 0 : pend[1] - (h[4] ? 256 : 0);
            dy = h[7] ? 0 : pend[2] - (h[5] ? 256 : 0);
            mx = clampi(mx + dx, X_MAX);
            my = clampi(my - dy, Y_MAX);
            ml = h[0];
            mr = h[1];
            exp_q.push_back('{mx, my, ml, mr});
            pend.delete();
        end
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // bad: bit0 flips parity, bit1 clears stop, bit2 sets start.
    task automatic send_frame(input int b, input int bad);
        logic [10:0] f;
        logic [7:0]  d;
        model_frame(b, bad != 0);
        d     = 8'(b);
        f[0]  = (bad & 4) != 0;
        f[8:1] = d;
        f[9]  = ~(^d) ^ ((bad & 1) != 0);
        f[10] = (bad & 2) == 0;
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_packet(input int b0, input int b1, input int b2);
        send_frame(b0, 0);
        send_frame(b1, 0);
        send_frame(b2, 0);
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) ps2_bit(i == 0 ? 1'b0 : 1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_xpos", xpos, 0);
        chk("rst_ypos", ypos, 0);
        chk("rst_btn", {left, right}, 0);
        chk("rst_evt", evt, 0);
        rst = 1'b0;
        mx = 0; my = 0; ml = 0; mr = 0;
        pend.delete();
        repeat (5) @(negedge clk);
    endtask

    // Monitor: every evt consumes one prediction; otherwise outputs must hold.
    exp_t cur = '{0, 0, 0, 0};
    always @(negedge clk) begin
        if (rst) begin
            cur = '{0, 0, 0, 0};
        end else if (evt) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: xpos %0d ypos %0d with no packet pending", xpos, ypos);
            end else begin
                cur = exp_q.pop_front();
                chk("ev_xpos", xpos, cur.x);
                chk("ev_ypos", ypos, cur.y);
                chk("ev_left", left, cur.l);
                chk("ev_right", right, cur.r);
            end
        end else begin
            chk("hold", {xpos, ypos, left, right}, {12'(cur.x), 12'(cur.y), cur.l, cur.r});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, bad;
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        mx = 0; my = 0; ml = 0; mr = 0;
        repeat (4) @(negedge clk);
        chk("init_xpos", xpos, 0);
        chk("init_ypos", ypos, 0);
        chk("init_btn", {left, right}, 0);
        chk("init_evt", evt, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic move with left button and negative Y delta.
        send_packet(8'h29, 8'h10, 8'hF6);

        // Reset in the middle of a packet and a frame.
        send_frame(8'h08, 0);
        send_partial(4);
        do_reset();
        send_packet(8'h28, 8'h03, 8'hFE);

        // Clamp at X_MAX.
        do_reset();
        repeat (4) send_packet(8'h08, 8'hFF, 8'h00);
        send_packet(8'h08, 8'h10, 8'h00);
        // Clamp at Y_MAX.
        repeat (3) send_packet(8'h28, 8'h00, 8'h00);

        // Clamp at 0, then X overflow leaves xpos alone.
        do_reset();
        send_packet(8'h08, 8'h05, 8'h00);
        send_packet(8'h18, 8'hF0, 8'h00);
        send_packet(8'h08, 8'h20, 8'h00);
        send_packet(8'h48, 8'h10, 8'h00);

        // Bad parity in byte1, then a clean packet.
        send_frame(8'h08, 0);
        send_frame(8'h05, 1);
        send_packet(8'h08, 8'h01, 8'h01);

        // Resync past a byte without bit3.
        send_frame(8'h00, 0);
        send_packet(8'h0A, 8'h00, 8'h00);

        // Bad stop and bad start bits.
        send_frame(8'h08, 0);
        send_frame(8'h10, 2);
        send_packet(8'h08, 8'h02, 8'h00);
        send_frame(8'h09, 4);
        send_packet(8'h09, 8'h03, 8'h00);

        // Stall mid-frame beyond the timeout.
        send_frame(8'h08, 0);
        send_partial(5);
        repeat (TMO + 1) @(negedge clk);
        model_frame(0, 1'b1);
        send_packet(8'h08, 8'h07, 8'h05);

        // Randomized stream including junk headers and corrupted frames.
        for (int i = 0; i < 60; i++) begin
            b = int'($urandom_range(0, 255));
            if (pend.size() == 0 && $urandom_range(0, 4) != 0) b = b | 8;
            bad = ($urandom_range(0, 9) == 0) ? (1 << $urandom_range(0, 2)) : 0;
            send_frame(b, bad);
        end

        repeat (100) @(negedge clk);
        chk("pending_events", exp_q.size(), 0);
        chk("final_xpos", xpos, mx);
        chk("final_ypos", ypos, my);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mouse_pos_tracker.md
MOUSE_POS_TRACKER -- requirements
Module: mouse_pos_tracker

Interface
REQ-001 SHALL have parameter X_MAX, default 1023: largest xpos value.
REQ-002 SHALL have parameter Y_MAX, default 767: largest ypos value.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65000: clk cycles without a PS/2 falling edge before a partial frame is dropped.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is synchronous to it.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port ps2_clk, input, 1 bit: PS/2 clock from the mouse, asynchronous to clk.
REQ-007 SHALL have port ps2_data, input, 1 bit: PS/2 data from the mouse, asynchronous to clk.
REQ-008 SHALL have port xpos, output, 12 bits: cursor column, 0..X_MAX.
REQ-009 SHALL have port ypos, output, 12 bits: cursor row, 0..Y_MAX, increasing downward.
REQ-010 SHALL have port left, output, 1 bit: left button state.
REQ-011 SHALL have port right, output, 1 bit: right button state.
REQ-012 SHALL have port event, output, 1 bit: one-cycle pulse, high in the cycle the outputs take a new packet's values.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through 2-FF synchronizers; a bit is sampled on a synced ps2_clk 1->0 transition.
REQ-014 Frame format SHALL be 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-015 Bit receiver SHALL have states IDLE and SHIFT, with bit counter 0..10; the last bit returns it to IDLE.
REQ-016 A frame with start=1, wrong parity or stop=0 SHALL be discarded and SHALL force the packet FSM to WAIT_B0.
REQ-017 In SHIFT, TIMEOUT_CYCLES cycles with no falling edge SHALL return the receiver to IDLE and the packet FSM to WAIT_B0.
REQ-018 Packet FSM SHALL have states WAIT_B0, WAIT_B1, WAIT_B2 and UPDATE; each accepted byte advances one state.
REQ-019 UPDATE SHALL last exactly one cycle and then go to WAIT_B0.
REQ-020 In WAIT_B0, a byte with bit3=0 SHALL be ignored and the FSM SHALL stay in WAIT_B0 (resync).
REQ-021 Byte0 fields SHALL be: bit0 L, bit1 R, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
REQ-022 dx SHALL be the 9-bit two's-complement value {Xsign, byte1}; dy SHALL be {Ysign, byte2}.
REQ-023 An axis whose overflow bit is set SHALL use delta 0 for that packet.
REQ-024 On leaving UPDATE, outputs SHALL be set as follows:
- xpos = clamp(xpos + dx, 0, X_MAX)
- ypos = clamp(ypos - dy, 0, Y_MAX)
- left and right from byte0
- event = 1 for that cycle only
REQ-025 Arithmetic SHALL use signed 14-bit intermediates, so no wrap-around is possible before clamping.
REQ-026 Latency SHALL be at most 3 clk cycles from the synced falling edge of byte2's stop bit to event.
REQ-027 All outputs SHALL be registered and SHALL hold their values between events.
REQ-028 The block SHALL be receive-only; host-to-device commands (streaming enable 0xF4) are out of scope and handled elsewhere.

Reset
REQ-029 On rst, SHALL set xpos=0, ypos=0, left=0, right=0 and event=0.
REQ-030 On rst, SHALL put the receiver in IDLE with counter 0, the packet FSM in WAIT_B0, and clear the timeout counter and synchronizers.
REQ-031 A reset asserted mid-frame or mid-packet SHALL abandon it; no event SHALL result from pre-reset bits.

Structure
REQ-032 Shared package mouse_pkg SHALL hold:
- the packet FSM state typedef
- byte0 bit-position constants
- the frame length constant (11)
REQ-033 Bit-level reception (sync, edge detect, shift, parity, timeout) SHALL be a sub-module ps2_rx producing a byte, a byte_valid strobe and a frame_err strobe.

Verification
REQ-034 Reset: assert rst mid-frame -> all outputs 0; a subsequent valid packet decodes normally.
REQ-035 Valid move from (0,0): bytes 0x29, 0x10, 0xF6 -> xpos=16, ypos=10, left=1, right=0, exactly one event pulse.
REQ-036 Clamping:
- From xpos=1020, bytes 0x08, 0x10, 0x00 -> xpos=1023.
- From xpos=5, bytes 0x18, 0xF0, 0x00 -> xpos=0.
- X overflow with byte0 0x48 -> xpos unchanged.
REQ-037 Parity error: byte1 sent with bad parity -> no event; the following packet 0x08, 0x01, 0x01 -> xpos+1, ypos-1 (clamped at 0).
REQ-038 Resync: byte 0x00 followed by packet 0x0A, 0x00, 0x00 -> the 0x00 is ignored, right=1, one event, position unchanged.
REQ-039 Timeout: ps2_clk stops after 5 bits for TIMEOUT_CYCLES+1 cycles -> no event; the next full packet decodes correctly.
